// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg : constants, FSM encoding and flat-bus indexing shared by    |
// |           the convolution output collector and the pooling stage.     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package cnn_pkg;

  localparam int BUF_WIDTH = 26;
  localparam int MAP_SIZE  = 32;

  // Largest positive value representable in a signed BUF_WIDTH pixel.
  localparam logic [BUF_WIDTH-1:0] BUF_MAX = {1'b0, {(BUF_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int unsigned pix_lsb(input int unsigned r,
                                          input int unsigned c,
                                          input int unsigned map_size,
                                          input int unsigned buf_width);
    return (r * map_size + c) * buf_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_relu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | requant_relu : bias add, round-half-up arithmetic shift, ReLU and    |
// |                saturation to a signed BUF_WIDTH pixel (combinational).|
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module requant_relu
  import cnn_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int BUF_WIDTH = cnn_pkg::BUF_WIDTH,
  parameter int SHIFT     = 4
) (
  input  logic [ACC_WIDTH-1:0] data_i,
  input  logic [ACC_WIDTH-1:0] bias_i,
  output logic [BUF_WIDTH-1:0] result_o,
  output logic                 sat_o
);

  // Two guard bits: one for the bias add, one for the rounding add.
  localparam int W = ACC_WIDTH + 2;
  localparam logic signed [W-1:0] RND  = W'(1) << (SHIFT - 1);
  localparam logic signed [W-1:0] MAXV = (W'(1) << (BUF_WIDTH - 1)) - W'(1);

  logic signed [W-1:0] data_x;
  logic signed [W-1:0] bias_x;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] q;

  always_comb begin
    data_x   = {{2{data_i[ACC_WIDTH-1]}}, data_i};
    bias_x   = {{2{bias_i[ACC_WIDTH-1]}}, bias_i};
    sum      = data_x + bias_x + RND;
    q        = sum >>> SHIFT;
    result_o = '0;
    sat_o    = 1'b0;
    if (q[W-1]) begin
      result_o = '0;
    end else if (q > MAXV) begin
      result_o = MAXV[BUF_WIDTH-1:0];
      sat_o    = 1'b1;
    end else begin
      result_o = q[BUF_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/relu_map_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relu_map_collector : collects a raster-order requantised ReLU map,   |
// |                      hands it to pooling and holds it until release.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module relu_map_collector
  import cnn_pkg::*;
#(
  parameter int BUF_WIDTH = cnn_pkg::BUF_WIDTH,
  parameter int MAP_SIZE  = cnn_pkg::MAP_SIZE,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ACC_WIDTH-1:0]                   bias,
  input  logic                                   in_valid,
  input  logic                                   in_sof,
  input  logic [ACC_WIDTH-1:0]                   in_data,
  output logic                                   in_ready,
  input  logic                                   release_i,
  output logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0] ofm,
  output logic                                   start,
  output logic                                   busy,
  output logic                                   sat_flag,
  output logic                                   sync_err
);

  localparam int NPIX = MAP_SIZE * MAP_SIZE;
  localparam int CW   = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAP_SIZE - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 sat_flag_q, sat_flag_d;
  logic                 sync_err_q, sync_err_d;
  logic                 wr_en;
  logic [CW-1:0]        wr_row, wr_col;
  logic [AW-1:0]        wr_idx;
  logic [BUF_WIDTH-1:0] px_res;
  logic                 px_sat;
  logic                 at_origin;
  logic [BUF_WIDTH-1:0] map_q [NPIX];

  requant_relu #(
    .ACC_WIDTH (ACC_WIDTH),
    .BUF_WIDTH (BUF_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requant (
    .data_i   (in_data),
    .bias_i   (bias),
    .result_o (px_res),
    .sat_o    (px_sat)
  );

  assign at_origin = (row_q == '0) && (col_q == '0);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    sat_flag_d = sat_flag_q;
    sync_err_d = sync_err_q;
    wr_en      = 1'b0;
    wr_row     = row_q;
    wr_col     = col_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          sat_flag_d = sat_flag_q | px_sat;
          if (in_sof && !at_origin) begin
            // Stray start-of-frame: restart the frame with this pixel at (0,0).
            sync_err_d = 1'b1;
            wr_row     = '0;
            wr_col     = '0;
            row_d      = '0;
            col_d      = CW'(1);
          end else begin
            if (!in_sof && at_origin) begin
              sync_err_d = 1'b1;
            end
            if (col_q == LAST) begin
              col_d = '0;
              if (row_q == LAST) begin
                row_d   = '0;
                state_d = ST_EMIT;
              end else begin
                row_d = row_q + CW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      ST_EMIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (release_i) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    wr_idx = AW'(int'(wr_row) * MAP_SIZE + int'(wr_col));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_FILL;
      row_q      <= '0;
      col_q      <= '0;
      sat_flag_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sat_flag_q <= sat_flag_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NPIX; i++) begin
        map_q[i] <= '0;
      end
    end else if (wr_en) begin
      map_q[wr_idx] <= px_res;
    end
  end

  for (genvar r = 0; r < MAP_SIZE; r++) begin : g_row
    for (genvar c = 0; c < MAP_SIZE; c++) begin : g_col
      assign ofm[pix_lsb(r, c, MAP_SIZE, BUF_WIDTH) +: BUF_WIDTH] = map_q[r*MAP_SIZE + c];
    end
  end

  assign in_ready = (state_q == ST_FILL);
  assign start    = (state_q == ST_EMIT);
  assign busy     = (state_q != ST_FILL) || !at_origin;
  assign sat_flag = sat_flag_q;
  assign sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_map_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_relu_map_collector : directed and randomised checks of the map    |
// |                         collector against hand-computed pixels.       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_relu_map_collector;
  import cnn_pkg::*;

  localparam int BW   = 26;
  localparam int NPIX = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      bias;
  logic             in_valid;
  logic             in_sof;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             release_i;
  logic [BW*NPIX-1:0] ofm;
  logic             start;
  logic             busy;
  logic             sat_flag;
  logic             sync_err;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_map [NPIX];

  always #5 clk = ~clk;

  relu_map_collector #(
    .BUF_WIDTH (26),
    .MAP_SIZE  (32),
    .ACC_WIDTH (32),
    .SHIFT     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .release_i (release_i),
    .ofm       (ofm),
    .start     (start),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .sync_err  (sync_err)
  );

  function automatic logic [BW-1:0] px(input int idx);
    return ofm[idx*BW +: BW];
  endfunction

  function automatic longint ref_q(input logic [31:0] d, input logic [31:0] b);
    longint s;
    s = longint'(signed'(d)) + longint'(signed'(b));
    return (s + 64'sd8) >>> 4;
  endfunction

  function automatic logic [BW-1:0] ref_px(input logic [31:0] d, input logic [31:0] b);
    longint q;
    q = ref_q(d, b);
    if (q < 0) return '0;
    if (q > longint'(BUF_MAX)) return BUF_MAX;
    return q[BW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one pixel after 'gap' idle cycles and returns #1 after the accept edge.
  task automatic send_pixel(input logic [31:0] d, input logic [31:0] b,
                            input logic sof, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_data  = d;
    bias     = b;
    in_sof   = sof;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout in_ready=%0b after %0d cycles", in_ready, n);
    end
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic pulse_release();
    release_i = 1'b1;
    step();
    release_i = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    rst_n    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; bias = '0; release_i = 1'b0;
    step(); step();
    rst_n = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start got=%0b want=0", start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat got=%0b want=0", sat_flag); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync got=%0b want=0", sync_err); end
    total++; if (ofm !== '0) begin bad++; $display("FAIL rst_ofm got nonzero want=0"); end
  endtask

  task automatic test_datapath();
    logic [31:0] d;
    for (int i = 0; i < NPIX; i++) begin
      case (i)
        0:       begin d = 32'd160;        exp_map[i] = 26'd10; end
        1:       begin d = -32'sd5;        exp_map[i] = 26'd0; end
        2:       begin d = 32'd8;          exp_map[i] = 26'd1; end
        3:       begin d = 32'd7;          exp_map[i] = 26'd0; end
        4:       begin d = 32'h7FFF_FFFF;  exp_map[i] = 26'd33554431; end
        default: begin d = 32'(16 * i);    exp_map[i] = BW'(i); end
      endcase
      send_pixel(d, 32'd0, (i == 0), 0);
      if (i == 0) begin
        total++; if (px(0) !== 26'd10) begin bad++; $display("FAIL dp_first_px got=%0d want=10", px(0)); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL dp_busy_fill got=%0b want=1", busy); end
      end
      if (i == 4) begin
        total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL dp_sat got=%0b want=1", sat_flag); end
      end
      if (i == NPIX - 2) begin
        total++; if (start !== 1'b0) begin bad++; $display("FAIL dp_start_early got=%0b want=0", start); end
      end
    end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL dp_start got=%0b want=1", start); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL dp_ready_emit got=%0b want=0", in_ready); end
    step();
    total++; if (start !== 1'b0) begin bad++; $display("FAIL dp_start_pulse got=%0b want=0", start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dp_busy_hold got=%0b want=1", busy); end
    for (int i = 0; i < NPIX; i++) begin
      total++;
      if (px(i) !== exp_map[i]) begin bad++; $display("FAIL dp_map[%0d] got=%0d want=%0d", i, px(i), exp_map[i]); end
    end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL dp_sync got=%0b want=0", sync_err); end
  endtask

  task automatic test_backpressure();
    in_data = 32'(16 * 777); bias = '0; in_sof = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b want=0", k, in_ready); end
    end
    for (int i = 0; i < NPIX; i++) begin
      total++;
      if (px(i) !== exp_map[i]) begin bad++; $display("FAIL bp_frozen[%0d] got=%0d want=%0d", i, px(i), exp_map[i]); end
    end
    pulse_release();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", in_ready); end
    total++; if (px(0) !== 26'd10) begin bad++; $display("FAIL bp_px0_before got=%0d want=10", px(0)); end
    step();
    in_valid = 1'b0; in_sof = 1'b0;
    total++; if (px(0) !== 26'd777) begin bad++; $display("FAIL bp_px0_after got=%0d want=777", px(0)); end
    total++; if (px(1) !== 26'd0) begin bad++; $display("FAIL bp_px1 got=%0d want=0", px(1)); end
  endtask

  task automatic test_sync();
    for (int i = 1; i < 167; i++) send_pixel(32'(16 * (i + 2000)), 32'd0, 1'b0, 0);
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sync_pre got=%0b want=0", sync_err); end
    total++; if (px(166) !== 26'd2166) begin bad++; $display("FAIL sync_px166 got=%0d want=2166", px(166)); end
    send_pixel(32'(16 * 42), 32'd0, 1'b1, 0);
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sync_err got=%0b want=1", sync_err); end
    total++; if (px(0) !== 26'd42) begin bad++; $display("FAIL sync_px0 got=%0d want=42", px(0)); end
    total++; if (px(167) !== 26'd167) begin bad++; $display("FAIL sync_px167 got=%0d want=167", px(167)); end
    exp_map[0] = 26'd42;
    for (int k = 1; k < NPIX; k++) begin
      exp_map[k] = BW'(k + 3000);
      send_pixel(32'(16 * (k + 3000)), 32'd0, 1'b0, 0);
      if (k == NPIX - 2) begin
        total++; if (start !== 1'b0) begin bad++; $display("FAIL sync_start_early got=%0b want=0", start); end
      end
    end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL sync_start got=%0b want=1", start); end
    step();
    for (int i = 0; i < NPIX; i++) begin
      total++;
      if (px(i) !== exp_map[i]) begin bad++; $display("FAIL sync_map[%0d] got=%0d want=%0d", i, px(i), exp_map[i]); end
    end
  endtask

  task automatic test_bias();
    pulse_release();
    for (int i = 0; i < NPIX; i++) send_pixel(32'd48, -32'sd32, (i == 0), 0);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL bias_start got=%0b want=1", start); end
    step();
    for (int i = 0; i < NPIX; i++) begin
      total++;
      if (px(i) !== 26'd1) begin bad++; $display("FAIL bias_map[%0d] got=%0d want=1", i, px(i)); end
    end
  endtask

  task automatic test_reset_midframe();
    pulse_release();
    for (int i = 0; i < 500; i++) send_pixel(32'(16 * i + 3), 32'd0, (i == 0), 0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", busy); end
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", in_ready); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL mid_start got=%0b want=0", start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_rst got=%0b want=0", busy); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL mid_sat got=%0b want=0", sat_flag); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mid_sync got=%0b want=0", sync_err); end
    total++; if (ofm !== '0) begin bad++; $display("FAIL mid_ofm got nonzero want=0"); end
    for (int i = 0; i < NPIX; i++) send_pixel(32'(16 * i + 3), 32'd0, (i == 0), 0);
    total++; if (start !== 1'b1) begin bad++; $display("FAIL mid_frame_start got=%0b want=1", start); end
    step();
    for (int i = 0; i < NPIX; i++) begin
      total++;
      if (px(i) !== BW'(i)) begin bad++; $display("FAIL mid_map[%0d] got=%0d want=%0d", i, px(i), i); end
    end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL mid_sync_after got=%0b want=0", sync_err); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL mid_sat_after got=%0b want=0", sat_flag); end
  endtask

  task automatic test_missing_sof();
    pulse_release();
    send_pixel(32'(16 * 55), 32'd0, 1'b0, 0);
    total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL nosof_sync got=%0b want=1", sync_err); end
    total++; if (px(0) !== 26'd55) begin bad++; $display("FAIL nosof_px0 got=%0d want=55", px(0)); end
    total++; if (px(1) !== 26'd1) begin bad++; $display("FAIL nosof_px1 got=%0d want=1", px(1)); end
  endtask

  task automatic test_random();
    logic [31:0] d, b;
    logic        exp_sat;
    int          dly;
    do_reset();
    exp_sat = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d = 32'(signed'(d) >>> $urandom_range(4, 30));
        b = 32'(signed'($urandom) >>> $urandom_range(2, 31));
        exp_map[i] = ref_px(d, b);
        if (ref_q(d, b) > longint'(BUF_MAX)) exp_sat = 1'b1;
        send_pixel(d, b, (i == 0), $urandom_range(0, 2));
      end
      total++; if (start !== 1'b1) begin bad++; $display("FAIL rnd%0d_start got=%0b want=1", f, start); end
      step();
      for (int i = 0; i < NPIX; i++) begin
        total++;
        if (px(i) !== exp_map[i]) begin bad++; $display("FAIL rnd%0d_map[%0d] got=%0d want=%0d", f, i, px(i), exp_map[i]); end
      end
      total++; if (sat_flag !== exp_sat) begin bad++; $display("FAIL rnd%0d_sat got=%0b want=%0b", f, sat_flag, exp_sat); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rnd%0d_sync got=%0b want=0", f, sync_err); end
      dly = $urandom_range(0, 20);
      repeat (dly) step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rnd%0d_hold_ready got=%0b want=0", f, in_ready); end
      pulse_release();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd%0d_rel_ready got=%0b want=1", f, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_backpressure();
    test_sync();
    test_bias();
    test_reset_midframe();
    test_missing_sof();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/relu_map_collector.md
Name: relu_map_collector

Overview:
- Sits directly upstream of the max-pooling stage.
- Accepts the convolution accumulator stream one pixel per cycle in raster order, and adds a per-map bias to each pixel.
- Each biased pixel is rounded and right-shifted, passed through ReLU, then saturated to BUF_WIDTH. The result is written into a MAP_SIZE x MAP_SIZE register map.
- When the map is complete, it presents the map on the flat ifm-format bus and issues a one-cycle start pulse to pooling. It then holds the map until pooling releases it.

Parameters:
- BUF_WIDTH, 26, signed output pixel width; matches the pooling stage.
- MAP_SIZE, 32, map height and width.
- ACC_WIDTH, 32, signed width of incoming convolution accumulator.
- SHIFT, 4, arithmetic right-shift (requantisation) applied after bias; legal range 1..ACC_WIDTH-1.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high (port name kept per codebase convention; asserted = 1).
- bias  input  ACC_WIDTH  signed bias; sampled on every accepted pixel.
- in_valid  input  1  input pixel valid.
- in_sof  input  1  qualifies the first pixel of a frame; meaningful only with in_valid.
- in_data  input  ACC_WIDTH  signed accumulator value.
- in_ready  output  1  block can accept a pixel this cycle.
- release  input  1  pulse from downstream: pooling has consumed the map.
- ofm  output  BUF_WIDTH*MAP_SIZE*MAP_SIZE  flat map; pixel (r,c) at bits [(r*MAP_SIZE+c+1)*BUF_WIDTH-1 -: BUF_WIDTH].
- start  output  1  one-cycle pulse: map complete and valid; drives pooling start.
- busy  output  1  high in FILL with at least one pixel accepted, and in EMIT and HOLD.
- sat_flag  output  1  sticky: some pixel saturated since last reset.
- sync_err  output  1  sticky: in_sof seen mid-frame, or first pixel of a frame lacked in_sof.

Behaviour:
Reset values:
- While rst_n=1 at a clock edge: state=FILL, row=col=0, every ofm pixel=0.
- Also in reset: start=0, sat_flag=0, sync_err=0, busy=0.
- After reset, in_ready=1 from the first cycle.
- Reset mid-frame or mid-HOLD discards all progress.

Handshake:
- A pixel is accepted on an edge where in_valid && in_ready.
- in_ready is combinational from state only: it is 1 exactly in FILL.

Per-pixel datapath, applied at the accept edge; pixel (row,col) is written at that edge, so ofm reflects it in the next cycle:
- s = in_data + bias, computed at ACC_WIDTH+1 bits with no wrap.
- q = (s + 2^(SHIFT-1)) >>> SHIFT. The shift is arithmetic and rounds half toward +inf.
- ReLU: if q < 0, result 0.
- Saturation: else if q > 2^(BUF_WIDTH-1)-1, result 2^(BUF_WIDTH-1)-1 and sat_flag set.
- Otherwise the result is q.

Counters:
- col increments per accepted pixel.
- At col=MAP_SIZE-1, col wraps to 0 and row increments.

State machine:
- FILL: accept pixels. Accepting the pixel at (MAP_SIZE-1, MAP_SIZE-1) moves to EMIT and clears the counters.
- EMIT: lasts one cycle with start=1, then goes to HOLD. start therefore rises in the cycle after the last accept.
- HOLD:
  - in_ready=0 and ofm is frozen.
  - release=1 returns to FILL on the next edge.
  - release in FILL or EMIT is ignored.
- The map is not cleared on return to FILL; pixels are overwritten as they arrive.

Sync rules:
- in_sof accepted at a position other than (0,0): set sync_err, write this pixel to (0,0), and set col=1 (restart frame).
- Pixel accepted at (0,0) without in_sof: set sync_err, but still accept it as (0,0).
- in_valid while not in FILL: pixel not accepted and no state change; the source must hold it.

Decomposition:
- Shared package cnn_pkg: BUF_WIDTH and MAP_SIZE defaults (shared with pooling), plus the flat-bus index function pix_lsb(r,c).
- Also in cnn_pkg: saturation constant BUF_MAX = 2^(BUF_WIDTH-1)-1.
- Sub-module requant_relu: purely combinational bias/round/shift/ReLU/saturate. Outputs result and sat bit; parameters ACC_WIDTH, BUF_WIDTH, SHIFT.
- Top-level contents: FSM, counters, map registers.

Test Plan:
1. Datapath values, with bias=0, SHIFT=4, one frame:
   - pixel(0,0)=160 -> 10; pixel(0,1)=-5 -> 0; pixel(0,2)=8 -> 1; pixel(0,3)=7 -> 0.
   - pixel(0,4)=2^31-1 -> 33554431 with sat_flag=1.
   - All other pixels equal to 16*(r*32+c) -> r*32+c.
   - After 1024 accepts, start is high for exactly one cycle, one cycle after the last accept.
2. Bias: bias=-32, in_data=48 everywhere -> every pixel equals 1. Then feed the map to pooling; every pooled output must be 1.
3. Backpressure:
   - After start, hold in_valid=1 for 100 cycles: in_ready=0 and ofm unchanged.
   - Pulse release: in_ready=1 on the next cycle, and the next pixel lands at (0,0).
4. Sync errors:
   - in_sof on the pixel accepted at (5,7): sync_err=1, and this pixel is written to (0,0).
   - Completing the frame then needs 1023 further accepts before start.
5. Reset: rst_n=1 for one cycle at pixel 500 -> all outputs and ofm zero, in_ready=1 on the following cycle. A fresh 1024-pixel frame then completes normally.
6. Random: random in_valid gaps and random bias. Compare the full ofm against a reference model over 3 back-to-back frames, each with a release delay of 0-20 cycles.
